key_scan: RTL and testbench
===========================

# key_scan

Scanned 4x4 matrix keypad reader for the digital clock board. It drives one active-low column at a time, samples the active-low rows, and debounces the result over whole scans. It reports one registered key code per accepted press. It is the input-side counterpart of the multiplexed segment display: it steps through the matrix with a clock-enable tick and never uses a derived clock. Its outputs feed the clock controller in place of raw switch lines.

## Interface
- SCAN_DIV, 5000: clk cycles per column step. Legal range 4..2^32-1.
- DEB_SCANS, 4: number of consecutive identical complete scans needed to accept a press or a release. Legal range 1..15.
- clk  in  1  system clock, 50 MHz nominal. Clock clk.
- rst_n  in  1  reset rst_n, asynchronous, active-low.
- o_col  out  4  column drive, active-low, one-cold.
- i_row  in  4  row sense, active-low, externally pulled up, asynchronous to clk.
- o_key  out  4  last accepted key code, {col[1:0], row[1:0]}. Held until the next acceptance.
- o_key_valid  out  1  one-clk pulse when o_key is updated.
- o_key_held  out  1  level; high from acceptance until the release is accepted.
- o_multi  out  1  level; high when the last completed scan saw two or more pressed keys.

## Operation
- Tick divider: counter counts 0..SCAN_DIV-1 and wraps. tick = (counter == SCAN_DIV-1).
- On each tick, col_idx advances 0→1→2→3→0. o_col = ~(4'b0001 << col_idx).
- i_row passes through a 2-flop synchronizer. On a tick the synchronized rows are sampled for the current col_idx, before the column advances.
- Per-scan accumulator:
  - npress (0..16) counts pressed keys.
  - cand_code holds the first pressed key found, lowest col then lowest row.
- End of scan is the tick with col_idx==3. The scan result is classified as:
  - NONE: npress == 0.
  - SINGLE(cand_code): npress == 1.
  - MULTI: npress >= 2.
- At end of scan, o_multi is updated and the accumulator clears.
- Debounce FSM, evaluated only at end of scan. deb_cnt is 4 bits.
  - IDLE: SINGLE(c) → cand=c, deb_cnt=1, go to PRESS_CHK. NONE or MULTI → stay.
  - PRESS_CHK:
    - SINGLE(cand) → deb_cnt+1.
    - When deb_cnt+1 == DEB_SCANS → o_key=cand, pulse o_key_valid, o_key_held=1, go to HELD.
    - Any other result → deb_cnt=0, go to IDLE.
    - When DEB_SCANS == 1, acceptance happens on the IDLE→SINGLE scan itself, going straight to HELD.
  - HELD:
    - NONE → deb_cnt=1, go to RELEASE_CHK. When DEB_SCANS == 1, go straight to IDLE and clear o_key_held.
    - SINGLE of another key, or MULTI → stay. No rollover: a new key is never reported until the release is accepted.
  - RELEASE_CHK:
    - NONE → deb_cnt+1. When it reaches DEB_SCANS → o_key_held=0, go to IDLE.
    - Any key → go to HELD. o_key_held stays 1 throughout.
- o_key is not cleared on release.

## Timing
- Reset values: counter=0, col_idx=0, o_col=4'b1110, o_key=0, o_key_valid=0, o_key_held=0, o_multi=0, FSM=IDLE, deb_cnt=0, synchronizer=4'b1111.
- Column dwell is SCAN_DIV cycles. Scan period is 4*SCAN_DIV cycles.
- Row sampling happens SCAN_DIV-1 cycles after the column switch. The 2-cycle synchronizer latency is covered because SCAN_DIV ≥ 4.
- o_key, o_key_valid, o_key_held and o_multi are registered. They change in the clk after the end-of-scan tick.
- o_key_valid is high for exactly one clk per accepted press.
- Press latency: a key stable across a scan boundary is accepted after DEB_SCANS complete scans. A press beginning mid-scan may cost one extra scan.
- Reset asserted mid-operation:
  - All state clears immediately.
  - No pulse is emitted.
  - Scanning restarts from col 0.

## Structure
- Shared package:
  - FSM state encoding: IDLE, PRESS_CHK, HELD, RELEASE_CHK.
  - KEY_W=4 and COL_N=ROW_N=4.
  - Scan-result enum: NONE, SINGLE, MULTI.
- One sub-module, key_scan_tick:
  - SCAN_DIV counter producing the tick enable and col_idx.
  - Reused by future scanned inputs.
- Synchronizer, accumulator and FSM live in key_scan.

## Test plan
Bench settings: SCAN_DIV=8, DEB_SCANS=3, scan=32 clk. The row model drives i_row[r]=0 iff o_col[c]==0 and key (c,r) is pressed.

- Reset: release rst_n → o_col=1110 for 8 clk, then 1101, 1011, 0111, 1110. All other outputs are 0.
- Clean press: key (c2,r1) held for 10 scans → exactly one o_key_valid pulse, o_key=4'd9. The pulse arrives after the 3rd complete scan containing the key. o_key_held=1 until after release.
- Bounce:
  - Key pressed for 1 scan, released, then pressed for 2 scans → no o_key_valid.
  - The 2-scan press followed by a 3rd scan → pulse.
- Multi: keys (c0,r0) and (c3,r3) held together → o_multi=1 after the first scan, no o_key_valid. Release (c3,r3) → o_multi=0, then a pulse with o_key=4'd0 after 3 scans.
- Release and rollover:
  - While key 9 is held, press key 5 and release key 9 → no new pulse.
  - Release all for 3 scans → o_key_held=0.
  - Press key 5 → second pulse with o_key=4'd5.
- Reset mid-PRESS_CHK: assert rst_n low after 2 matching scans → no pulse. Press restarts with a full 3-scan qualification.

Source files
------------

// File: rtl/key_scan_pkg.sv
// Shared definitions for the scanned keypad reader.
//   KEY_W        width of a key code {col[1:0], row[1:0]}
//   COL_N/ROW_N  matrix dimensions
//   deb_state_t  debounce FSM states
//   scan_res_t   classification of one complete scan
package key_scan_pkg;

  localparam int KEY_W = 4;
  localparam int COL_N = 4;
  localparam int ROW_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_HELD        = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } deb_state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } scan_res_t;

endpackage

// File: rtl/key_scan_tick.sv
// Column-step timebase for scanned inputs.
// Counts 0..SCAN_DIV-1 and wraps. The tick is asserted on the last count, and
// col_idx advances on each tick. Everything is clock-enable based: no derived clocks.
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   tick     one-clk enable, high when the counter is at SCAN_DIV-1
//   col_idx  current column being driven, 0..COL_N-1
module key_scan_tick
  import key_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick,
  output logic [1:0] col_idx
);

  logic [31:0] count;

  assign tick = (count == SCAN_DIV - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      col_idx <= '0;
    end else if (tick) begin
      count   <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      count   <= count + 32'd1;
    end
  end

endmodule

// File: rtl/key_scan.sv
// 4x4 matrix keypad reader.
// Drives one active-low column at a time. It samples the synchronized active-low
// rows at the end of each column dwell. The hits are accumulated over a full scan,
// and each scan is classified as NONE, SINGLE or MULTI. A debounce FSM then accepts
// a press or a release only after DEB_SCANS consecutive qualifying scans.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   o_col        column drive, active-low, one-cold
//   i_row        row sense, active-low, asynchronous to clk
//   o_key        last accepted key code {col, row}, held until the next acceptance
//   o_key_valid  one-clk pulse when o_key is updated
//   o_key_held   high from acceptance until the release is accepted
//   o_multi      high when the last completed scan saw two or more pressed keys
module key_scan
  import key_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 5000,
  parameter int unsigned DEB_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [COL_N-1:0] o_col,
  input  logic [ROW_N-1:0] i_row,
  output logic [KEY_W-1:0] o_key,
  output logic             o_key_valid,
  output logic             o_key_held,
  output logic             o_multi
);

  localparam logic [3:0] DEB_TARGET = 4'(DEB_SCANS);
  localparam bit         ONE_SCAN   = (DEB_SCANS == 1);

  // ---------------------------------------------------------------- timebase
  logic       tick;
  logic [1:0] col_idx;
  logic       eos;

  key_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .col_idx (col_idx)
  );

  assign o_col = ~(4'b0001 << col_idx);
  // The last column's tick closes the scan.
  assign eos   = tick && (col_idx == 2'(COL_N - 1));

  // ------------------------------------------------------------ synchronizer
  logic [ROW_N-1:0] row_meta;
  logic [ROW_N-1:0] row_sync;

  // Reset to all-released so no phantom press is seen coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= i_row;
      row_sync <= row_meta;
    end
  end

  // ------------------------------------------------- per-column contribution
  logic [ROW_N-1:0] col_hits;
  logic [2:0]       col_cnt;
  logic [1:0]       first_row;

  assign col_hits = ~row_sync;

  always_comb begin
    // NOTE: every variable of a combinational block gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    col_cnt   = '0;
    first_row = '0;
    // Walk downward so the lowest pressed row wins.
    for (int r = ROW_N - 1; r >= 0; r--) begin
      if (col_hits[r]) first_row = 2'(r);
    end
    for (int r = 0; r < ROW_N; r++) begin
      col_cnt = col_cnt + 3'(col_hits[r]);
    end
  end

  // ------------------------------------------------------- scan accumulator
  logic [4:0]       npress;
  logic [KEY_W-1:0] cand_code;
  logic [4:0]       scan_npress;
  logic [KEY_W-1:0] scan_cand;
  scan_res_t        scan_res;

  // The scan result includes the column sampled on the closing tick itself.
  assign scan_npress = npress + {2'b00, col_cnt};
  assign scan_cand   = (npress == 5'd0) ? {col_idx, first_row} : cand_code;

  always_comb begin
    scan_res = RES_NONE;
    if (scan_npress == 5'd1)      scan_res = RES_SINGLE;
    else if (scan_npress >= 5'd2) scan_res = RES_MULTI;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      npress    <= '0;
      cand_code <= '0;
      o_multi   <= 1'b0;
    end else if (tick) begin
      if (eos) begin
        npress    <= '0;
        cand_code <= '0;
        o_multi   <= (scan_res == RES_MULTI);
      end else begin
        npress <= scan_npress;
        // The first hit of the scan is the lowest column, lowest row.
        if (npress == 5'd0 && col_cnt != 3'd0) cand_code <= {col_idx, first_row};
      end
    end
  end

  // ------------------------------------------------------------ debounce FSM
  deb_state_t       state, state_nxt;
  logic [3:0]       deb_cnt, deb_nxt;
  logic [3:0]       deb_inc;
  logic [KEY_W-1:0] cand, cand_nxt;
  logic [KEY_W-1:0] key_nxt;
  logic             valid_nxt;
  logic             held_nxt;

  assign deb_inc = deb_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      deb_cnt     <= '0;
      cand        <= '0;
      o_key       <= '0;
      o_key_valid <= 1'b0;
      o_key_held  <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_nxt;
      cand        <= cand_nxt;
      o_key       <= key_nxt;
      o_key_valid <= valid_nxt;
      o_key_held  <= held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    cand_nxt  = cand;
    key_nxt   = o_key;
    valid_nxt = 1'b0;
    held_nxt  = o_key_held;
    if (eos) begin
      case (state)
        ST_IDLE: begin
          if (scan_res == RES_SINGLE) begin
            cand_nxt = scan_cand;
            if (ONE_SCAN) begin
              key_nxt   = scan_cand;
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              deb_nxt   = '0;
              state_nxt = ST_HELD;
            end else begin
              deb_nxt   = 4'd1;
              state_nxt = ST_PRESS_CHK;
            end
          end
        end
        ST_PRESS_CHK: begin
          if (scan_res == RES_SINGLE && scan_cand == cand) begin
            if (deb_inc == DEB_TARGET) begin
              key_nxt   = cand;
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              deb_nxt   = '0;
              state_nxt = ST_HELD;
            end else begin
              deb_nxt = deb_inc;
            end
          end else begin
            // A different key or a multi-press restarts qualification from scratch.
            deb_nxt   = '0;
            state_nxt = ST_IDLE;
          end
        end
        ST_HELD: begin
          // No rollover: any key activity keeps us here until a clean release.
          if (scan_res == RES_NONE) begin
            if (ONE_SCAN) begin
              held_nxt  = 1'b0;
              deb_nxt   = '0;
              state_nxt = ST_IDLE;
            end else begin
              deb_nxt   = 4'd1;
              state_nxt = ST_RELEASE_CHK;
            end
          end
        end
        default: begin // ST_RELEASE_CHK
          if (scan_res == RES_NONE) begin
            if (deb_inc == DEB_TARGET) begin
              held_nxt  = 1'b0;
              deb_nxt   = '0;
              state_nxt = ST_IDLE;
            end else begin
              deb_nxt = deb_inc;
            end
          end else begin
            deb_nxt   = '0;
            state_nxt = ST_HELD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// Self-checking bench for key_scan with SCAN_DIV=8, DEB_SCANS=3 (32 clk per scan).
// A matrix model pulls row r low while column c is driven and key (c,r) is pressed.
// Keys change only at scan boundaries. A scan-level reference model predicts the
// outputs after each scan.
module tb_key_scan;

  localparam int DIV  = 8;
  localparam int DEB  = 3;
  localparam int SCAN = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic       multi;

  bit [15:0]  keys = '0;   // bit index = {col, row}

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] m_key;
  logic       m_held;
  logic       m_multi;
  logic       m_pulse;
  int         m_streak;
  int         m_cand;

  always #5 clk = ~clk;

  key_scan #(.SCAN_DIV(DIV), .DEB_SCANS(DEB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .o_col       (col),
    .i_row       (row),
    .o_key       (key),
    .o_key_valid (key_valid),
    .o_key_held  (key_held),
    .o_multi     (multi)
  );

  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_key = '0; m_held = 1'b0; m_multi = 1'b0; m_pulse = 1'b0;
    m_streak = 0; m_cand = -1;
  endtask

  // Debounce rules applied to one whole-scan snapshot of the pressed set.
  task automatic model_scan();
    int n = 0;
    int first = -1;
    for (int k = 0; k < 16; k++) if (keys[k]) begin n++; if (first < 0) first = k; end
    m_pulse = 1'b0;
    m_multi = (n >= 2);
    if (!m_held) begin
      if (n == 1) begin
        if (m_streak > 0 && first != m_cand) m_streak = 0;
        else begin m_cand = first; m_streak++; end
        if (m_streak == DEB) begin
          m_pulse = 1'b1; m_held = 1'b1; m_key = 4'(first); m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
    end else begin
      if (n == 0) begin
        m_streak++;
        if (m_streak == DEB) begin m_held = 1'b0; m_streak = 0; end
      end else begin
        m_streak = 0;
      end
    end
  endtask

  // Runs one scan with the given pressed set; entered and left on a negedge
  // that directly follows a scan boundary.
  task automatic do_scan(input bit [15:0] set);
    logic [3:0] exp_col;
    keys = set;
    model_scan();
    for (int i = 0; i < SCAN; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_col = ~(4'b0001 << (((i + 1) / DIV) % 4));
      check("col", col, exp_col);
      if (i == SCAN - 1) begin
        check("valid_eos", key_valid, m_pulse);
        check("key", key, m_key);
        check("held", key_held, m_held);
        check("multi", multi, m_multi);
      end else begin
        check("valid_mid", key_valid, 1'b0);
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_col", col, 4'hE);
    check("rst_key", key, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    check("rst_multi", multi, 1'b0);
  endtask

  initial begin
    model_reset();
    // Power-on reset
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    do_scan(16'h0000);

    // Clean press of key 9 (c2,r1) for 10 scans, then release
    repeat (10) do_scan(16'h0200);
    check("clean_key9", key, 4'd9);
    check("clean_held", key_held, 1'b1);
    repeat (3) do_scan(16'h0000);
    check("clean_released", key_held, 1'b0);

    // Bounce: 1 scan, gap, 2 scans (no pulse), then a 3rd scan (pulse)
    do_scan(16'h0200);
    do_scan(16'h0000);
    repeat (2) do_scan(16'h0200);
    do_scan(16'h0200);
    repeat (4) do_scan(16'h0000);

    // Multi: keys 0 and 15 together, then release 15
    repeat (4) do_scan(16'h8001);
    repeat (3) do_scan(16'h0001);
    check("multi_key0", key, 4'd0);
    repeat (3) do_scan(16'h0000);

    // Rollover: key 9 held, key 5 added, key 9 dropped, release, press key 5
    repeat (4) do_scan(16'h0200);
    repeat (2) do_scan(16'h0220);
    repeat (2) do_scan(16'h0020);
    check("roll_still9", key, 4'd9);
    repeat (3) do_scan(16'h0000);
    repeat (4) do_scan(16'h0020);
    check("roll_key5", key, 4'd5);
    repeat (3) do_scan(16'h0000);

    // Reset in the middle of press qualification
    repeat (2) do_scan(16'h0200);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_col", col, 4'hE);
      check("rst_hold_valid", key_valid, 1'b0);
    end
    rst_n = 1'b1;
    repeat (2) do_scan(16'h0200);
    check("rst_requal_nopulse_held", key_held, 1'b0);
    do_scan(16'h0200);
    check("rst_requal_key9", key, 4'd9);
    repeat (3) do_scan(16'h0000);

    // Randomized scans checked against the model
    begin
      bit [15:0] prev = '0;
      bit [15:0] set;
      for (int s = 0; s < 40; s++) begin
        int mode = $urandom_range(0, 9);
        if (mode <= 2)      set = '0;
        else if (mode <= 6) set = prev;
        else if (mode <= 8) set = 16'(1) << $urandom_range(0, 15);
        else                set = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        do_scan(set);
        prev = set;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
